// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential double-dabble binary-to-BCD converter.
package bin2bcd_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StConv,
        StDone
    } state_e;

    localparam logic [3:0] ADJ_THRESH = 4'd5;
    localparam logic [3:0] ADJ_ADD    = 4'd3;

    // Decimal digits needed to represent 2^bin_w - 1.
    function automatic int unsigned min_digits(input int unsigned bin_w);
        longint unsigned max_val;
        int unsigned     n;
        max_val = (64'd1 << bin_w) - 64'd1;
        n       = 1;
        while (max_val >= 64'd10) begin
            max_val = max_val / 64'd10;
            n++;
        end
        return n;
    endfunction

endpackage

// File: rtl/bin2bcd_seq_adj.sv
// Single BCD digit adjust for double-dabble: adds 3 to a digit of 5 or more, no carry out.
module bcd_digit_adj
    import bin2bcd_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [3:0] digit_o
);

    always_comb begin
        digit_o = digit_i;
        if (digit_i >= ADJ_THRESH) begin
            digit_o = digit_i + ADJ_ADD;
        end
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Multi-cycle binary-to-BCD converter (shift-and-add-3), start/busy/done handshake.
// Define BIN2BCD_EXCESS3_EN to emit each result digit in excess-3 code.
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int unsigned BIN_W  = 8,
    parameter int unsigned DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned SR_W  = BCD_W + BIN_W;
    localparam int unsigned CNT_W = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

    if (BIN_W < 4 || BIN_W > 32) begin : g_bad_width
        $error("bin2bcd_seq: BIN_W=%0d outside 4..32", BIN_W);
    end
    if (DIGITS < min_digits(BIN_W)) begin : g_bad_digits
        $error("bin2bcd_seq: DIGITS=%0d too small for BIN_W=%0d (need %0d)",
               DIGITS, BIN_W, min_digits(BIN_W));
    end

    state_e             state_q;
    logic [SR_W-1:0]    sr_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               busy_q;
    logic               done_q;
    logic [BCD_W-1:0]   bcd_q;

    logic [BCD_W-1:0]   bcd_adj;
    logic [SR_W-1:0]    sr_shift;
    logic [BCD_W-1:0]   bcd_result;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit_i (sr_q[BIN_W + 4*g +: 4]),
            .digit_o (bcd_adj[4*g +: 4])
        );
    end

    // Adjust all digits in parallel, then shift the whole register left by one.
    assign sr_shift = {bcd_adj[BCD_W-2:0], sr_q[BIN_W-1:0], 1'b0};

    always_comb begin
        bcd_result = sr_shift[SR_W-1 -: BCD_W];
`ifdef BIN2BCD_EXCESS3_EN
        for (int unsigned i = 0; i < DIGITS; i++) begin
            bcd_result[4*i +: 4] = sr_shift[BIN_W + 4*i +: 4] + ADJ_ADD;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            sr_q    <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            bcd_q   <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q <= StConv;
                        busy_q  <= 1'b1;
                        sr_q    <= {{BCD_W{1'b0}}, bin_in};
                        cnt_q   <= '0;
                    end
                end
                StConv: begin
                    sr_q  <= sr_shift;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_CNT) begin
                        state_q <= StDone;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        bcd_q   <= bcd_result;
                    end
                end
                StDone: begin
                    done_q <= 1'b0;
                    // A start here is taken immediately so results can stream back to back.
                    if (start) begin
                        state_q <= StConv;
                        busy_q  <= 1'b1;
                        sr_q    <= {{BCD_W{1'b0}}, bin_in};
                        cnt_q   <= '0;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign bcd_out = bcd_q;

endmodule
